// File: rtl/mac_pkg.sv
// Shared types and constants for the multiply-add result path.
// Latency: none (declarations only).
// Backpressure: not applicable.
package mac_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        EMIT  = 1'b1
    } state_t;

    localparam int Y_W       = 32;
    localparam int DEF_ACC_W = 40;

    localparam logic [Y_W-1:0] SAT_MAX = 32'h7FFF_FFFF;
    localparam logic [Y_W-1:0] SAT_MIN = 32'h8000_0000;

endpackage

// File: rtl/sat_clamp.sv
// Narrows a wide signed accumulator to 32 bits and flags out-of-range values.
// Latency: purely combinational.
// Backpressure: none; FRAME_ACCUM_SAT_EN selects clamping, otherwise two's-complement wrap.
module sat_clamp
    import mac_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic [ACC_W-1:0] acc,
    output logic [Y_W-1:0]   y,
    output logic             ovf
);

    // Bits from the 32-bit sign position upward; in range only when all agree.
    logic [ACC_W-Y_W:0] upper;
    assign upper = acc[ACC_W-1:Y_W-1];

    // Range check and narrowing.
    always_comb begin
        ovf = !((&upper) || !(|upper));
        y   = acc[Y_W-1:0];
`ifdef FRAME_ACCUM_SAT_EN
        if (ovf) begin
            y = acc[ACC_W-1] ? SAT_MIN : SAT_MAX;
        end
`endif
    end

endmodule

// File: rtl/frame_accum.sv
// Sums FRAME_LEN signed results (or a flushed partial frame) and emits one frame sum.
// Latency: out_valid rises the cycle after the last sample is accepted; one bubble per frame.
// Backpressure: in_ready is low throughout EMIT; out_ready low holds EMIT indefinitely.
module frame_accum
    import mac_pkg::*;
#(
    parameter int FRAME_LEN = 8,
    parameter int ACC_W     = DEF_ACC_W,
    parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [Y_W-1:0]   in_y,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [Y_W-1:0]   out_sum,
    output logic [CNT_W-1:0] out_cnt,
    output logic             out_ovf
);

    localparam logic [CNT_W-1:0] FRAME_LEN_C = CNT_W'(FRAME_LEN);

    state_t             state_q;
    state_t             state_d;
    logic [ACC_W-1:0]   acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               out_valid_q;
    logic [Y_W-1:0]     out_sum_q;
    logic [CNT_W-1:0]   out_cnt_q;
    logic               out_ovf_q;

    logic               accept;
    logic               load_out;
    logic               clear;
    logic [ACC_W-1:0]   acc_inc;
    logic [CNT_W-1:0]   cnt_inc;
    logic [ACC_W-1:0]   acc_fin;
    logic [CNT_W-1:0]   cnt_fin;
    logic [Y_W-1:0]     sum_narrow;
    logic               sum_ovf;

    assign acc_inc = acc_q + {{(ACC_W-Y_W){in_y[Y_W-1]}}, in_y};
    assign cnt_inc = cnt_q + CNT_W'(1);

    // Frame totals including a sample accepted on the closing cycle.
    assign acc_fin = accept ? acc_inc : acc_q;
    assign cnt_fin = accept ? cnt_inc : cnt_q;

    sat_clamp #(
        .ACC_W (ACC_W)
    ) u_sat_clamp (
        .acc (acc_fin),
        .y   (sum_narrow),
        .ovf (sum_ovf)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake controls; in_ready depends on state only.
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        accept   = 1'b0;
        load_out = 1'b0;
        clear    = 1'b0;
        case (state_q)
            ACCUM: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if ((accept && (cnt_inc == FRAME_LEN_C)) ||
                    (flush && ((cnt_q != '0) || accept))) begin
                    state_d  = EMIT;
                    load_out = 1'b1;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    state_d = ACCUM;
                    clear   = 1'b1;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    // Accumulator and sample counter; cleared once the frame is handed off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (clear) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (accept) begin
            acc_q <= acc_inc;
            cnt_q <= cnt_inc;
        end
    end

    // Output registers: captured on entry to EMIT, held until the next frame closes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_cnt_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else if (load_out) begin
            out_valid_q <= 1'b1;
            out_sum_q   <= sum_narrow;
            out_cnt_q   <= cnt_fin;
            out_ovf_q   <= sum_ovf;
        end else if (clear) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_cnt   = out_cnt_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_frame_accum.sv
// Directed bench for frame_accum with FRAME_LEN=4.
// Latency: checks sample 1 ns after each rising edge.
// Backpressure: exercises out_ready held low during EMIT.
module tb_frame_accum;

    localparam int FRAME_LEN = 4;
    localparam int ACC_W     = 40;
    localparam int CNT_W     = 3;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_y;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_sum;
    logic [CNT_W-1:0] out_cnt;
    logic             out_ovf;

    int checks = 0;
    int errors = 0;

    frame_accum #(
        .FRAME_LEN (FRAME_LEN),
        .ACC_W     (ACC_W),
        .CNT_W     (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_y      (in_y),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cnt   (out_cnt),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one sample for one cycle (optionally with flush), then idle the inputs.
    task automatic push(input logic [31:0] y, input logic fl);
        in_valid = 1'b1;
        in_y     = y;
        flush    = fl;
        step();
        in_valid = 1'b0;
        flush    = 1'b0;
        in_y     = 32'h0;
    endtask

    task automatic check_frame(input string tag, input logic [31:0] sum,
                               input logic [CNT_W-1:0] cnt, input logic ovf);
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_sum"},   64'(out_sum),   64'(sum));
        chk({tag, "_cnt"},   64'(out_cnt),   64'(cnt));
        chk({tag, "_ovf"},   64'(out_ovf),   64'(ovf));
        chk({tag, "_rdy"},   64'(in_ready),  64'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_y      = 32'h0;
        flush     = 1'b0;
        out_ready = 1'b1;
        #12;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_sum",   64'(out_sum),   64'd0);
        chk("rst_cnt",   64'(out_cnt),   64'd0);
        chk("rst_ovf",   64'(out_ovf),   64'd0);
        chk("rst_rdy",   64'(in_ready),  64'd1);
        rst_n = 1'b1;
        step();

        // 1,2,3,4 -> 10; output rises the cycle after the 4th sample.
        push(32'd1, 1'b0);
        push(32'd2, 1'b0);
        push(32'd3, 1'b0);
        chk("f1_early_valid", 64'(out_valid), 64'd0);
        push(32'd4, 1'b0);
        check_frame("f1", 32'd10, 3'd4, 1'b0);
        step();
        chk("f1_rdy_back",  64'(in_ready),  64'd1);
        chk("f1_valid_low", 64'(out_valid), 64'd0);
        chk("f1_sum_kept",  64'(out_sum),   64'd10);

        // Mixed signs -> -8.
        push(32'hFFFF_FFFB, 1'b0);
        push(32'd3, 1'b0);
        push(32'hFFFF_FFF9, 1'b0);
        push(32'd1, 1'b0);
        check_frame("f2", 32'hFFFF_FFF8, 3'd4, 1'b0);
        step();

        // 4 x 0x7FFFFFFF = 0x1_FFFF_FFFC overflows the 32-bit range.
        for (int i = 0; i < 4; i++) push(32'h7FFF_FFFF, 1'b0);
`ifdef FRAME_ACCUM_SAT_EN
        check_frame("f3", 32'h7FFF_FFFF, 3'd4, 1'b1);
`else
        check_frame("f3", 32'hFFFF_FFFC, 3'd4, 1'b1);
`endif
        step();

        // Flush together with a third sample -> 17 over 3 samples.
        push(32'd6, 1'b0);
        push(32'd9, 1'b0);
        push(32'd2, 1'b1);
        check_frame("f4", 32'd17, 3'd3, 1'b0);
        step();

        // Flush on an empty frame produces nothing.
        flush = 1'b1;
        step();
        step();
        flush = 1'b0;
        chk("empty_valid", 64'(out_valid), 64'd0);
        chk("empty_rdy",   64'(in_ready),  64'd1);
        chk("empty_sum",   64'(out_sum),   64'd17);

        // Back-pressure: hold EMIT for 5 cycles while the next sample waits.
        out_ready = 1'b0;
        push(32'd10, 1'b0);
        push(32'd20, 1'b0);
        push(32'd30, 1'b0);
        push(32'd40, 1'b0);
        in_valid = 1'b1;
        in_y     = 32'd5;
        for (int i = 0; i < 5; i++) begin
            check_frame("bp", 32'd100, 3'd4, 1'b0);
            step();
        end
        check_frame("bp_end", 32'd100, 3'd4, 1'b0);
        out_ready = 1'b1;
        step();
        chk("bp_release_valid", 64'(out_valid), 64'd0);
        push(32'd5, 1'b0);
        push(32'd6, 1'b0);
        push(32'd7, 1'b0);
        push(32'd8, 1'b0);
        check_frame("f5", 32'd26, 3'd4, 1'b0);
        step();

        // Asynchronous reset mid-EMIT discards the frame.
        out_ready = 1'b0;
        push(32'd1, 1'b0);
        push(32'd2, 1'b0);
        push(32'd3, 1'b0);
        push(32'd4, 1'b0);
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_sum",   64'(out_sum),   64'd0);
        chk("async_rst_rdy",   64'(in_ready),  64'd1);
        #2;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) push(32'd1, 1'b0);
        check_frame("f6", 32'd4, 3'd4, 1'b0);
        step();
        chk("end_valid", 64'(out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_accum.md
Name: frame_accum

Overview:
- Downstream neighbour of the three-stage multiply-add pipeline.
- Consumes its 32-bit signed result stream over a valid/ready handshake and sums FRAME_LEN consecutive results into a wide accumulator.
- Emits one frame sum per frame, with a sample count and an overflow flag, to the next consumer over a second valid/ready handshake.
- Sits between the multiply-add pipeline and the result sink / register readout.

Parameters:
- FRAME_LEN, 8: number of results summed per frame; legal range is 2 or more.
- ACC_W, 40: internal accumulator width in bits; legal range is 33 or more.
- CNT_W, $clog2(FRAME_LEN+1): width of the sample counter and of out_cnt (derived).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- in_valid  in  1  upstream result valid.
- in_ready  out  1  block can accept a result this cycle.
- in_y  in  32  signed result from the multiply-add pipeline.
- flush  in  1  close the current partial frame early.
- out_valid  out  1  frame sum valid.
- out_ready  in  1  downstream accepts the frame sum.
- out_sum  out  32  signed frame sum.
- out_cnt  out  CNT_W  number of samples in the emitted frame.
- out_ovf  out  1  accumulator exceeded the signed 32-bit range.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = ACCUM; acc = 0; cnt = 0.
  - out_valid = 0; out_sum = 0; out_cnt = 0; out_ovf = 0.
  - An in-flight frame is discarded, including during EMIT: out_valid drops immediately.
- State machine, two states: ACCUM and EMIT.
- ACCUM:
  - in_ready = 1; out_valid = 0.
  - Accept when in_valid && in_ready: acc <= acc + sign-extended in_y (ACC_W, wraps at ACC_W); cnt <= cnt + 1.
  - Go to EMIT when the accepted sample makes cnt == FRAME_LEN.
  - flush high in ACCUM with (cnt > 0 or a sample accepted this cycle) -> go to EMIT. A simultaneously accepted sample is included in the frame.
  - flush with cnt == 0 and no sample accepted -> ignored.
- On entry to EMIT (registered on the same edge):
  - out_sum = final acc, converted to 32 bits (see Optional Feature).
  - out_cnt = final cnt.
  - out_ovf = 1 if the final acc is outside [-2^31, 2^31-1].
- EMIT:
  - in_ready = 0; out_valid = 1.
  - out_sum, out_cnt and out_ovf are held stable until the handshake.
  - On out_valid && out_ready: acc <= 0, cnt <= 0, out_valid <= 0, return to ACCUM. out_sum/out_cnt/out_ovf keep their last values.
  - flush in EMIT is ignored.
- Latency: out_valid rises the cycle after the last sample of the frame is accepted.
- Throughput: FRAME_LEN samples per FRAME_LEN+1 cycles when out_ready is tied high. The one bubble per frame is intentional.
- in_ready is a combinational function of state only and does not depend on in_valid. out_valid is registered.
- Back-pressure: out_ready low holds EMIT indefinitely. in_ready stays 0 and upstream stalls.
- in_y is ignored when in_valid is low.

Optional Feature:
- Macro: FRAME_ACCUM_SAT_EN.
- Defined: out_sum clamps to 32'h7FFFFFFF when the final acc > 2^31-1 and to 32'h80000000 when it is < -2^31.
- Undefined: out_sum = acc[31:0] (two's-complement wrap).
- out_ovf behaves identically in both builds.

Decomposition:
- Shared package mac_pkg:
  - state enum (ACCUM, EMIT);
  - constants Y_W = 32 and default ACC_W = 40;
  - constants SAT_MAX = 32'h7FFFFFFF and SAT_MIN = 32'h80000000.
- One sub-module, sat_clamp:
  - combinational; input ACC_W-bit value; outputs the 32-bit result and the ovf flag;
  - contains the FRAME_ACCUM_SAT_EN branch;
  - reusable by later accumulating stages.

Test Plan:
- FRAME_LEN=4, out_ready=1, in_y = 1, 2, 3, 4 on consecutive cycles -> one cycle later out_valid=1, out_sum=10, out_cnt=4, out_ovf=0; in_ready=0 for exactly one cycle.
- in_y = -5, 3, -7, 1 -> out_sum = -8 (32'hFFFFFFF8), out_ovf=0.
- Four samples of 32'h7FFFFFFF:
  - with FRAME_ACCUM_SAT_EN defined -> out_sum = 32'h7FFFFFFF, out_ovf=1;
  - without it -> out_sum = 32'hFFFFFFFC, out_ovf=1.
- flush edge cases:
  - in_y = 6, 9, then flush asserted together with a third sample 2 -> out_sum=17, out_cnt=3;
  - flush with an empty frame -> no output.
- Back-pressure: out_ready held 0 for 5 cycles during EMIT -> out_valid, out_sum and out_cnt stable, in_ready=0 throughout, no samples lost once out_ready returns.
- rst_n pulsed low mid-EMIT -> out_valid drops immediately (asynchronous). The next frame 1, 1, 1, 1 yields out_sum=4, showing no residue from the discarded frame.
